fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the unified memory block. It
//  owns the PC and issues single-word reads to memory: access_size 2'b00,
//  rw=1, one-cycle synchronous read latency. It buffers returned words with
//  their PC in a small FIFO and hands them to decode over a valid/ready
//  handshake. It supports branch/jump redirect with flush and a halt input.
// PARAMETERS
//  RESET_PC    32'h80020000  PC loaded on reset; equals the memory base_addr
//  FIFO_DEPTH  2             instruction buffer entries; power of 2, >=2
// PORTS
//  clock           in   1   single clock, all state updates on posedge
//  reset           in   1   synchronous, active-high
//  halt            in   1   1 = issue no new fetches (in-flight read still completes)
//  redirect_valid  in   1   1 = load redirect_pc and flush this cycle
//  redirect_pc     in   32  redirect target
//  mem_address     out  32  read address to memory
//  mem_access_size out  2   tied 2'b00 (single word)
//  mem_rw          out  1   tied 1 (read)
//  mem_enable      out  1   1 = read issued this cycle
//  mem_data_out    in   32  memory read data, valid the cycle after issue
//  insn_valid      out  1   FIFO head valid
//  insn            out  32  FIFO head instruction word
//  insn_pc         out  32  FIFO head PC
//  insn_ready      in   1   decode accepts head when insn_valid & insn_ready
//  misaligned      out  1   sticky: a redirect_pc with [1:0]!=0 was seen
// BEHAVIOUR
//  Reset (sync): pc<=RESET_PC, FIFO empty, inflight<=0, state<=S_BOOT,
//   misaligned<=0; outputs: mem_enable=0, insn_valid=0, mem_address=RESET_PC.
//  FSM: S_BOOT -> S_RUN after exactly one cycle. S_RUN is the only issuing
//   state. No other states.
//  Issue: mem_enable=1 iff S_RUN & !halt & !redirect_valid &
//   (count + inflight - pop) < FIFO_DEPTH.
//   pop = insn_valid & insn_ready. mem_address=pc, driven combinationally.
//   On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4, 32-bit wrap, no trap.
//  Return: in the cycle after issue, mem_data_out is valid. If inflight & !kill,
//   push {inflight_pc, mem_data_out}. Otherwise discard it. inflight clears
//   unless a new issue occurs the same cycle. The memory busy output is not
//   consumed; latency is fixed at 1.
//  Throughput: with insn_ready=1 held, one instruction per cycle. The first
//   insn_valid appears 2 cycles after the first issue cycle.
//  FIFO: push and pop in the same cycle are both honoured, and count is
//   unchanged. Push never occurs when full; the issue credit guarantees this.
//   Pop when empty is a no-op. The head is stable while insn_valid & !insn_ready.
//  Redirect (takes priority over all else): FIFO cleared, and a pop in the same
//   cycle is ignored. pc<={redirect_pc[31:2],2'b00}. If redirect_pc[1:0]!=0,
//   misaligned<=1. If a read is in flight or returns next cycle, kill<=1 and
//   that one response is dropped. No issue occurs in the redirect cycle. The
//   first fetch of the new target is issued the next cycle, if there is credit.
//  Halt: only issue is suppressed; the return, push and pop paths run normally.
//   Deasserting halt resumes at pc with no gap or duplicate.
//  Reset mid-operation overrides redirect and halt. Any return in flight at
//   reset is discarded.
// TESTING
//  1 reset, halt=0, insn_ready=1 -> S_BOOT one cycle; then mem_address
//    0x80020000,0x80020004,0x80020008 on consecutive cycles; insn_pc follows 2 cycles later.
//  2 insn_ready=0 from start -> exactly FIFO_DEPTH pushes, then mem_enable=0;
//    raise ready -> pcs 0x80020000.. delivered in order, none lost or duplicated.
//  3 redirect_valid=1, redirect_pc=0x80020100 while a read is in flight ->
//    stale word dropped, FIFO flushed, next insn_pc=0x80020100.
//  4 redirect_pc=0x80020102 -> misaligned=1 (sticky), fetch from 0x80020100.
//  5 halt=1 mid-stream, ready=1 -> in-flight word delivered, mem_enable=0;
//    halt=0 -> resumes at next sequential pc.
//  6 reset asserted with FIFO full and read in flight -> next cycle insn_valid=0,
//    mem_enable=0; fetch restarts at 0x80020000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-word reads with fixed
// one-cycle latency and buffers returned words with their PC for decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h80020000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        halt,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] mem_address,
   output logic [1:0]  mem_access_size,
   output logic        mem_rw,
   output logic        mem_enable,
   input  logic [31:0] mem_data_out,
   output logic        insn_valid,
   output logic [31:0] insn,
   output logic [31:0] insn_pc,
   input  logic        insn_ready,
   output logic        misaligned
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   typedef enum logic {S_BOOT, S_RUN} state_t;

   state_t        r_state;
   logic [31:0]   r_pc;
   logic [31:0]   r_inflight_pc;
   logic          r_inflight;
   logic          r_kill;
   logic          r_misaligned;
   logic [31:0]   r_fifo_insn [FIFO_DEPTH];
   logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_pop;
   logic          w_push;
   logic          w_issue;
   logic [CW:0]   w_demand;

   assign insn_valid      = (r_count != '0);
   assign insn            = r_fifo_insn[r_rd_ptr];
   assign insn_pc         = r_fifo_pc[r_rd_ptr];
   assign misaligned      = r_misaligned;
   assign mem_address     = r_pc;
   assign mem_access_size = 2'b00;
   assign mem_rw          = 1'b1;

   // Credit counts the in-flight read so a response always has a free slot.
   assign w_pop    = insn_valid & insn_ready & ~redirect_valid;
   assign w_push   = r_inflight & ~r_kill & ~redirect_valid;
   assign w_demand = {1'b0, r_count} + {{CW{1'b0}}, r_inflight}
                   - {{CW{1'b0}}, (insn_valid & insn_ready)};
   assign w_issue  = (r_state == S_RUN) & ~halt & ~redirect_valid & (w_demand < DEPTH_C);
   assign mem_enable = w_issue;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_BOOT;
         r_pc         <= RESET_PC;
         r_inflight   <= 1'b0;
         r_kill       <= 1'b0;
         r_misaligned <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
      end else begin
         r_state <= S_RUN;
         r_kill  <= redirect_valid & r_inflight;
         if (redirect_valid) begin
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            if (redirect_pc[1:0] != 2'b00)
               r_misaligned <= 1'b1;
         end else begin
            r_inflight <= w_issue;
            if (w_issue)
               r_pc <= r_pc + 32'd4;
            if (w_push)
               r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Datapath storage carries no reset; validity is tracked by the control above.
   always_ff @(posedge clock) begin
      if (w_issue)
         r_inflight_pc <= r_pc;
      if (w_push) begin
         r_fifo_insn[r_wr_ptr] <= mem_data_out;
         r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
      end
   end

endmodule
